// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: serial FIR sequencer; valid_in/ready_in/x sample in, coef_we/coef_addr/coef_data/coef_err coefficient bank, valid_out/y result, busy while accumulating
module fir_seq_ctrl #(
  parameter int TAPS = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_W-1:0]       x,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS):0]   coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_err,
  output logic                    valid_out,
  output logic [ACC_W-1:0]        y,
  output logic                    busy
);
  localparam int AW = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] d [TAPS];
  logic [COEF_W-1:0] h [TAPS];
  logic [ACC_W-1:0] acc, acc_nx;
  logic [DATA_W+COEF_W-1:0] prod;
  logic [AW-1:0] idx;
  logic accept, last, wr_ok;
  assign ready_in = state != MAC;
  assign busy = state == MAC;
  assign accept = valid_in & ready_in;
  assign last = idx == AW'(TAPS - 1);
  assign wr_ok = coef_we && state == IDLE && !coef_addr[AW];
  assign prod = {{DATA_W{1'b0}}, h[idx]} * {{COEF_W{1'b0}}, d[idx]};
  assign acc_nx = acc + ACC_W'(prod);
  always_comb begin
    state_nx = state;
    state_nx = busy ? (last ? OUT : MAC) : (accept ? MAC : IDLE);
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      y <= '0;
      valid_out <= 1'b0;
      coef_err <= 1'b0;
      acc <= '0;
      idx <= '0;
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        h[i] <= COEF_W'(1);
      end
    end else begin
      valid_out <= busy & last;
      coef_err <= coef_we & ~wr_ok;
      if (wr_ok) h[coef_addr[AW-1:0]] <= coef_data;
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) d[i] <= d[i-1];
        d[0] <= x;
        acc <= '0;
        idx <= '0;
      end else if (busy) begin
        acc <= acc_nx;
        idx <= idx + 1'b1;
        if (last) y <= acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench for the serial FIR sequencer
module tb_fir_seq_ctrl;
  logic clock = 0, reset = 1, valid_in = 0, coef_we = 0;
  logic ready_in, coef_err, valid_out, busy;
  logic [7:0] x = 0, coef_data = 0;
  logic [3:0] coef_addr = 0;
  logic [18:0] y;
  int checks = 0, errors = 0, cyc = 0, last_acc = -1;
  bit b2b = 0;
  logic [18:0] exp_q[$];
  int t_q[$];
  fir_seq_ctrl #(.TAPS(8), .DATA_W(8), .COEF_W(8), .ACC_W(19)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .valid_out(valid_out), .y(y), .busy(busy));
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset) t_q.delete();
    else begin
      chk("ready_vs_busy", ready_in, !busy);
      if (valid_in && ready_in) begin
        t_q.push_back(cyc);
        if (b2b && last_acc >= 0) begin
          chk("b2b_spacing", cyc - last_acc, 9);
          chk("b2b_accept_in_out", valid_out, 1);
        end
        last_acc = cyc;
      end
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_out: got y=%0d expected no result", y);
        end else chk("y", y, exp_q.pop_front());
        if (t_q.size() != 0) chk("latency", cyc - t_q.pop_front(), 9);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic send(input logic [7:0] v, input logic [18:0] e, input bit hold = 0);
    bit hs;
    int n = 0;
    x = v;
    valid_in = 1;
    exp_q.push_back(e);
    do begin
      @(negedge clock);
      hs = ready_in;
      tick();
      n++;
    end while (!hs && n < 100);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready_in expected accept of x=%0d", v);
    end
    if (!hold) valid_in = 0;
  endtask
  task automatic wcoef(input logic [3:0] a, input logic [7:0] v, input logic err);
    coef_we = 1;
    coef_addr = a;
    coef_data = v;
    tick();
    coef_we = 0;
    chk("coef_err", coef_err, err);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask
  initial begin
    logic [7:0] hv [8] = '{3, 0, 7, 1, 255, 2, 9, 4};
    reset = 1;
    repeat (2) begin
      valid_in = 1'($urandom);
      x = 8'($urandom);
      coef_we = 1'($urandom);
      coef_addr = 4'($urandom);
      coef_data = 8'($urandom);
      tick();
    end
    reset = 0;
    valid_in = 0;
    coef_we = 0;
    chk("rst_y", y, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_in", ready_in, 1);
    chk("rst_busy", busy, 0);
    chk("rst_coef_err", coef_err, 0);
    send(5, 5);
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(i), 19'(i * (i + 1) / 2));
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(4'(i), hv[i], 0);
    send(1, 19'(hv[0]));
    for (int i = 1; i < 8; i++) send(0, 19'(hv[i]));
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) wcoef(4'(i), 255, 0);
    b2b = 1;
    last_acc = -1;
    for (int n = 1; n <= 8; n++) send(255, 19'(n * 65025), 1);
    valid_in = 0;
    drain();
    b2b = 0;
    chk("full_scale_y", y, 520200);
    do_reset();
    send(10, 10);
    chk("mac_busy", busy, 1);
    wcoef(0, 0, 1);
    drain();
    send(3, 13);
    drain();
    wcoef(8, 0, 1);
    send(4, 17);
    drain();
    wcoef(1, 2, 0);
    send(1, 22);
    drain();
    exp_q.push_back(29);
    x = 2;
    valid_in = 1;
    coef_we = 1;
    coef_addr = 0;
    coef_data = 5;
    tick();
    valid_in = 0;
    coef_we = 0;
    drain();
    do_reset();
    wcoef(0, 5, 0);
    x = 7;
    valid_in = 1;
    tick();
    valid_in = 0;
    tick(4);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_y", y, 0);
    chk("abort_ready_in", ready_in, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid_out", valid_out, 0);
    tick(12);
    send(9, 9);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
